match_index_streamer: RTL and testbench
=======================================

// Module: match_index_streamer
// PURPOSE
//  Downstream consumer of the "101" pattern detector's match vector.
//  - Accepts one VEC_W-bit match vector per frame; bit i set = match starting at index i.
//  - Streams the index of every set bit, ascending, over a valid/ready interface.
//  - Reports the per-frame match count and a frame-done pulse.
//  - Sits between the detector and the result FIFO / UART reporter.
// PARAMETERS
//  VEC_W   14  width of match vector (number of candidate start positions)
//  IDX_W   4   width of emitted index; must satisfy 2**IDX_W >= VEC_W
//  CNT_W   5   width of match counter; must satisfy 2**CNT_W > VEC_W
// PORTS
//  clk          in   1      clock, all state changes on rising edge
//  reset        in   1      asynchronous, active-high reset
//  vec_valid    in   1      match_vec valid; upstream holds until accepted
//  vec_ready    out  1      block can accept a new vector
//  match_vec    in   VEC_W  match indicator vector
//  idx_valid    out  1      idx_data/idx_last valid
//  idx_ready    in   1      downstream accepts current index
//  idx_data     out  IDX_W  index of current match
//  idx_last     out  1      current index is the frame's final one
//  frame_done   out  1      one-cycle pulse: frame fully emitted
//  match_count  out  CNT_W  number of matches in the last completed frame
// BEHAVIOUR
//  - FSM states:
//    - IDLE: vec_ready=1. On vec_valid&vec_ready: pending<=match_vec, count<=0.
//      Go to EMIT if match_vec!=0, else go to DONE.
//    - EMIT: idx_valid=1. idx_data = index of lowest set bit of pending.
//      idx_last = (pending has exactly one bit set).
//      On idx_valid&idx_ready: clear that bit, count<=count+1. If idx_last, go to DONE.
//    - DONE: frame_done=1 for exactly one cycle; match_count<=final count; go to IDLE.
//  - Outputs depend only on registered state/pending. No combinational path input->output,
//    except vec_ready/idx_valid, which are derived from state only.
//  - Stall: while idx_valid&!idx_ready, idx_data and idx_last are held stable.
//  - vec_ready=0 in EMIT and DONE; vec_valid is ignored (not captured) there.
//  - Latency: accept -> first idx_valid = 1 cycle.
//    - Frame with n>0 matches and no stalls: accept at cycle 0, beats at cycles 1..n,
//      frame_done at n+1, vec_ready again at n+2.
//    - Empty frame: frame_done 1 cycle after accept; no idx beat.
//  - match_count updates in DONE and holds until the next frame's DONE.
//  - Reset (any time, incl. mid-EMIT): state=IDLE, pending=0, count=0.
//    - Reset output values: vec_ready=1, idx_valid=0, idx_data=0, idx_last=0,
//      frame_done=0, match_count=0.
//    - An interrupted frame produces no frame_done.
// TESTING
//  1. Reset with pending frame -> all outputs at reset values; vec_ready=1 next cycle.
//  2. match_vec=14'h0025, idx_ready=1 -> idx_data 0,2,5 on cycles 1..3, idx_last at 5;
//     frame_done cycle 4; match_count=3.
//  3. match_vec=0 -> no idx_valid; frame_done 1 cycle after accept; match_count=0.
//  4. match_vec=14'h3FFF, idx_ready toggling each cycle -> indices 0..13 in order;
//     data held on stall cycles; last on 13; match_count=14.
//  5. match_vec=14'h2000, idx_ready=0 for 5 cycles with a new vec_valid pending ->
//     idx_data=13 held with idx_last=1; vec_ready=0; second vector accepted only after DONE.
//  6. match_vec=14'h0111, reset asserted after 2 beats -> no frame_done;
//     next frame 14'h0004 emits idx 2 with match_count=1.

Source files
------------

// File: rtl/match_index_streamer.sv
// Streams the ascending indices of the set bits in a match vector over valid/ready,
// then pulses frame_done and latches the frame's match count.
module match_index_streamer #(
    parameter int VEC_W = 14,
    parameter int IDX_W = 4,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             vec_valid,
    output logic             vec_ready,
    input  logic [VEC_W-1:0] match_vec,
    output logic             idx_valid,
    input  logic             idx_ready,
    output logic [IDX_W-1:0] idx_data,
    output logic             idx_last,
    output logic             frame_done,
    output logic [CNT_W-1:0] match_count
);

    typedef enum logic [1:0] {IDLE, EMIT, DONE} state_t;

    state_t           state_reg, state_next;
    logic [VEC_W-1:0] pending_reg, pending_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic [CNT_W-1:0] match_count_reg, match_count_next;

    logic [VEC_W-1:0] low_onehot;
    logic [IDX_W-1:0] idx_term [VEC_W];
    logic [IDX_W-1:0] low_index;
    logic             single_bit;

    // Isolate the lowest set bit; its position is the index currently offered.
    assign low_onehot = pending_reg & (~pending_reg + VEC_W'(1));

    generate
        for (genvar gi = 0; gi < VEC_W; gi++) begin : g_idx_term
            assign idx_term[gi] = low_onehot[gi] ? IDX_W'(gi) : '0;
        end
    endgenerate

    always_comb begin
        low_index = '0;
        for (int i = 0; i < VEC_W; i++) begin
            low_index = low_index | idx_term[i];
        end
    end

    assign single_bit = (pending_reg != '0) && ((pending_reg & ~low_onehot) == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg       <= IDLE;
            pending_reg     <= '0;
            count_reg       <= '0;
            match_count_reg <= '0;
        end else begin
            state_reg       <= state_next;
            pending_reg     <= pending_next;
            count_reg       <= count_next;
            match_count_reg <= match_count_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        pending_next     = pending_reg;
        count_next       = count_reg;
        match_count_next = match_count_reg;
        case (state_reg)
            IDLE: begin
                if (vec_valid) begin
                    pending_next = match_vec;
                    count_next   = '0;
                    state_next   = (match_vec != '0) ? EMIT : DONE;
                end
            end
            EMIT: begin
                if (idx_ready) begin
                    pending_next = pending_reg & ~low_onehot;
                    count_next   = count_reg + CNT_W'(1);
                    if (single_bit) begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                match_count_next = count_reg;
                state_next       = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Pending is empty outside EMIT, so idx_data naturally reads 0 there.
    assign vec_ready   = (state_reg == IDLE);
    assign idx_valid   = (state_reg == EMIT);
    assign idx_data    = low_index;
    assign idx_last    = (state_reg == EMIT) && single_bit;
    assign frame_done  = (state_reg == DONE);
    assign match_count = match_count_reg;

endmodule

// File: tb/tb_match_index_streamer.sv
// Directed bench for match_index_streamer: drives inputs and samples outputs on the falling edge.
module tb_match_index_streamer;

    logic        clk = 1'b0;
    logic        reset;
    logic        vec_valid;
    logic        vec_ready;
    logic [13:0] match_vec;
    logic        idx_valid;
    logic        idx_ready;
    logic [3:0]  idx_data;
    logic        idx_last;
    logic        frame_done;
    logic [4:0]  match_count;

    int n_vec = 0;
    int n_err = 0;

    match_index_streamer dut (
        .clk         (clk),
        .reset       (reset),
        .vec_valid   (vec_valid),
        .vec_ready   (vec_ready),
        .match_vec   (match_vec),
        .idx_valid   (idx_valid),
        .idx_ready   (idx_ready),
        .idx_data    (idx_data),
        .idx_last    (idx_last),
        .frame_done  (frame_done),
        .match_count (match_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Present a vector in IDLE (must be ready) and let it be taken on the next edge.
    task automatic accept(input logic [13:0] v);
        vec_valid = 1'b1;
        match_vec = v;
        check("accept_vec_ready", 32'(vec_ready), 32'd1);
        tick();
        vec_valid = 1'b0;
    endtask

    task automatic check_beat(input string tag, input int data, input bit last);
        check({tag, "_valid"}, 32'(idx_valid), 32'd1);
        check({tag, "_data"}, 32'(idx_data), 32'(data));
        check({tag, "_last"}, 32'(idx_last), 32'(last));
    endtask

    initial begin
        int  e;
        bit  rdy;

        reset     = 1'b1;
        vec_valid = 1'b1;
        match_vec = 14'h0025;
        idx_ready = 1'b1;
        @(negedge clk);
        tick();

        // 1. reset held with a frame offered
        check("rst_vec_ready", 32'(vec_ready), 32'd1);
        check("rst_idx_valid", 32'(idx_valid), 32'd0);
        check("rst_idx_data", 32'(idx_data), 32'd0);
        check("rst_idx_last", 32'(idx_last), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_match_count", 32'(match_count), 32'd0);
        vec_valid = 1'b0;
        reset     = 1'b0;
        tick();
        check("post_rst_vec_ready", 32'(vec_ready), 32'd1);
        check("post_rst_idx_valid", 32'(idx_valid), 32'd0);

        // 2. 0x0025 streamed without stalls
        idx_ready = 1'b1;
        accept(14'h0025);
        check_beat("t2_b0", 0, 1'b0);
        check("t2_vec_ready_emit", 32'(vec_ready), 32'd0);
        tick();
        check_beat("t2_b1", 2, 1'b0);
        tick();
        check_beat("t2_b2", 5, 1'b1);
        tick();
        check("t2_frame_done", 32'(frame_done), 32'd1);
        check("t2_idx_valid_done", 32'(idx_valid), 32'd0);
        check("t2_vec_ready_done", 32'(vec_ready), 32'd0);
        tick();
        check("t2_frame_done_pulse", 32'(frame_done), 32'd0);
        check("t2_vec_ready_idle", 32'(vec_ready), 32'd1);
        check("t2_match_count", 32'(match_count), 32'd3);

        // 3. empty frame
        accept(14'h0000);
        check("t3_frame_done", 32'(frame_done), 32'd1);
        check("t3_idx_valid", 32'(idx_valid), 32'd0);
        tick();
        check("t3_frame_done_pulse", 32'(frame_done), 32'd0);
        check("t3_vec_ready", 32'(vec_ready), 32'd1);
        check("t3_match_count", 32'(match_count), 32'd0);

        // 4. all ones with idx_ready toggling, starting with a stall
        accept(14'h3FFF);
        e   = 0;
        rdy = 1'b0;
        for (int c = 0; c < 40 && e < 14; c++) begin
            check_beat("t4_beat", e, e == 13);
            idx_ready = rdy;
            if (rdy) e++;
            rdy = ~rdy;
            tick();
        end
        check("t4_all_beats", 32'(e), 32'd14);
        idx_ready = 1'b1;
        check("t4_frame_done", 32'(frame_done), 32'd1);
        tick();
        check("t4_match_count", 32'(match_count), 32'd14);

        // 5. single top bit stalled with a second vector waiting
        idx_ready = 1'b0;
        accept(14'h2000);
        vec_valid = 1'b1;
        match_vec = 14'h0003;
        for (int c = 0; c < 5; c++) begin
            check_beat("t5_stall", 13, 1'b1);
            check("t5_vec_ready_stall", 32'(vec_ready), 32'd0);
            tick();
        end
        idx_ready = 1'b1;
        tick();
        check("t5_frame_done", 32'(frame_done), 32'd1);
        check("t5_vec_ready_done", 32'(vec_ready), 32'd0);
        tick();
        check("t5_vec_ready_idle", 32'(vec_ready), 32'd1);
        check("t5_match_count", 32'(match_count), 32'd1);
        tick();
        vec_valid = 1'b0;
        check_beat("t5_second_b0", 0, 1'b0);
        tick();
        check_beat("t5_second_b1", 1, 1'b1);
        tick();
        check("t5_second_done", 32'(frame_done), 32'd1);
        tick();
        check("t5_second_count", 32'(match_count), 32'd2);

        // 6. reset mid-frame after two beats, then a fresh frame
        accept(14'h0111);
        check_beat("t6_b0", 0, 1'b0);
        tick();
        check_beat("t6_b1", 4, 1'b0);
        tick();
        check_beat("t6_b2", 8, 1'b1);
        reset = 1'b1;
        #1;
        check("t6_rst_idx_valid", 32'(idx_valid), 32'd0);
        check("t6_rst_vec_ready", 32'(vec_ready), 32'd1);
        check("t6_rst_idx_data", 32'(idx_data), 32'd0);
        check("t6_rst_idx_last", 32'(idx_last), 32'd0);
        check("t6_rst_match_count", 32'(match_count), 32'd0);
        tick();
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            check("t6_no_frame_done", 32'(frame_done), 32'd0);
            tick();
        end
        accept(14'h0004);
        check_beat("t6_new_b0", 2, 1'b1);
        tick();
        check("t6_new_done", 32'(frame_done), 32'd1);
        tick();
        check("t6_new_count", 32'(match_count), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
